cmos_sccb_ae_writer: RTL

CMOS_SCCB_AE_WRITER -- requirements
Module: cmos_sccb_ae_writer

---
 rtl/cmos_sccb_ae_writer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/cmos_sccb_ae_writer.sv
// rtl/cmos_sccb_ae_writer.sv - SCCB writer pushing AE exposure/gain into four sensor registers
module cmos_sccb_ae_writer #(
  parameter int         CLK_DIV    = 64,
  parameter logic [7:0] SLAVE_ID   = 8'h42,
  parameter logic [7:0] REG_EXP_H  = 8'h08,
  parameter logic [7:0] REG_EXP_L  = 8'h10,
  parameter logic [7:0] REG_GAIN_H = 8'h03,
  parameter logic [7:0] REG_GAIN_L = 8'h00
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       change_start,
  output logic       change_done,
  input  logic [9:0] exposure,
  input  logic [9:0] gain,
  output logic       sccb_scl,
  output logic       sccb_sda_oe,
  input  logic       sccb_sda_in,
  output logic       busy,
  output logic       nack
);

  localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, BYTE, XBIT, STOP, GAP} state_t;

  state_t     state, state_nxt;
  logic [1:0] quarter, quarter_nxt;
  logic [2:0] bit_idx, bit_nxt;
  logic [1:0] byte_idx, byte_nxt;
  logic [1:0] txn_idx, txn_nxt;
  logic [9:0] div_cnt, div_nxt;
  logic       qtick, qtick_nxt;
  logic       start_d, start_d_nxt;
  logic [9:0] exp_q, exp_nxt;
  logic [9:0] gain_q, gain_nxt;
  logic       busy_nxt, nack_nxt, done_nxt;
  logic       scl_nxt, sda_oe_nxt;
  logic       accept;
  logic [7:0] cur_byte;
  logic [1:0] level;

  // Byte 0 is the slave ID, byte 1 the sub-address, byte 2 the data for this transaction
  function automatic logic [7:0] byte_val(input logic [1:0] txn, input logic [1:0] byt,
                                          input logic [9:0] e, input logic [9:0] g);
    logic [7:0] v;
    v = SLAVE_ID;
    if (byt == 2'd1) begin
      case (txn)
        2'd0:    v = REG_EXP_H;
        2'd1:    v = REG_EXP_L;
        2'd2:    v = REG_GAIN_H;
        default: v = REG_GAIN_L;
      endcase
    end else if (byt == 2'd2) begin
      case (txn)
        2'd0:    v = {6'b0, e[9:8]};
        2'd1:    v = e[7:0];
        2'd2:    v = {6'b0, g[9:8]};
        default: v = g[7:0];
      endcase
    end
    return v;
  endfunction

  // Returns {scl, sda} for one quarter of the current bit
  function automatic logic [1:0] bus_level(input state_t s, input logic [1:0] q, input logic b);
    logic [1:0] lv;
    lv = 2'b11;
    case (s)
      START: lv = (q == 2'd0) ? 2'b11 : (q == 2'd3) ? 2'b00 : 2'b10;
      BYTE:  lv = {(q == 2'd1) || (q == 2'd2), b};
      XBIT:  lv = {(q == 2'd1) || (q == 2'd2), 1'b1};
      STOP:  lv = (q == 2'd0) ? 2'b00 : (q == 2'd1) ? 2'b10 : 2'b11;
      default: lv = 2'b11;
    endcase
    return lv;
  endfunction

  always_comb begin
    state_nxt   = state;
    quarter_nxt = quarter;
    bit_nxt     = bit_idx;
    byte_nxt    = byte_idx;
    txn_nxt     = txn_idx;
    div_nxt     = div_cnt;
    qtick_nxt   = 1'b0;
    start_d_nxt = change_start;
    exp_nxt     = exp_q;
    gain_nxt    = gain_q;
    busy_nxt    = busy;
    nack_nxt    = nack;
    done_nxt    = 1'b0;
    accept      = change_start && !start_d && !busy;

    if (state == IDLE) begin
      div_nxt = '0;
      if (accept) begin
        exp_nxt     = exposure;
        gain_nxt    = gain;
        nack_nxt    = 1'b0;
        busy_nxt    = 1'b1;
        state_nxt   = START;
        quarter_nxt = 2'd0;
        txn_nxt     = 2'd0;
        byte_nxt    = 2'd0;
        bit_nxt     = 3'd7;
      end
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_nxt   = '0;
        qtick_nxt = 1'b1;
      end else begin
        div_nxt = div_cnt + 10'd1;
      end

      if (qtick) begin
        // SCCB ignores the 9th bit; a high sample is only recorded
        if (state == XBIT && quarter == 2'd2 && sccb_sda_in)
          nack_nxt = 1'b1;
        if (quarter != 2'd3) begin
          quarter_nxt = quarter + 2'd1;
        end else begin
          quarter_nxt = 2'd0;
          case (state)
            START: begin
              state_nxt = BYTE;
              bit_nxt   = 3'd7;
            end
            BYTE: begin
              if (bit_idx == 3'd0) state_nxt = XBIT;
              else                 bit_nxt   = bit_idx - 3'd1;
            end
            XBIT: begin
              if (byte_idx == 2'd2) begin
                state_nxt = STOP;
              end else begin
                state_nxt = BYTE;
                byte_nxt  = byte_idx + 2'd1;
                bit_nxt   = 3'd7;
              end
            end
            STOP: state_nxt = GAP;
            GAP: begin
              if (txn_idx == 2'd3) begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                div_nxt   = '0;
                qtick_nxt = 1'b0;
              end else begin
                state_nxt = START;
                txn_nxt   = txn_idx + 2'd1;
                byte_nxt  = 2'd0;
              end
            end
            default: state_nxt = IDLE;
          endcase
        end
      end
    end

    cur_byte   = byte_val(txn_nxt, byte_nxt, exp_nxt, gain_nxt);
    level      = bus_level(state_nxt, quarter_nxt, cur_byte[bit_nxt]);
    scl_nxt    = level[1];
    sda_oe_nxt = ~level[0];
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      quarter     <= 2'd0;
      bit_idx     <= 3'd7;
      byte_idx    <= 2'd0;
      txn_idx     <= 2'd0;
      div_cnt     <= '0;
      qtick       <= 1'b0;
      start_d     <= 1'b0;
      exp_q       <= '0;
      gain_q      <= '0;
      busy        <= 1'b0;
      nack        <= 1'b0;
      change_done <= 1'b0;
      sccb_scl    <= 1'b1;
      sccb_sda_oe <= 1'b0;
    end else begin
      state       <= state_nxt;
      quarter     <= quarter_nxt;
      bit_idx     <= bit_nxt;
      byte_idx    <= byte_nxt;
      txn_idx     <= txn_nxt;
      div_cnt     <= div_nxt;
      qtick       <= qtick_nxt;
      start_d     <= start_d_nxt;
      exp_q       <= exp_nxt;
      gain_q      <= gain_nxt;
      busy        <= busy_nxt;
      nack        <= nack_nxt;
      change_done <= done_nxt;
      sccb_scl    <= scl_nxt;
      sccb_sda_oe <= sda_oe_nxt;
    end
  end

endmodule
